// File: rtl/nios_system_pio_in_edge.sv
// Avalon-MM input PIO: WIDTH-bit synchronised input, sticky per-bit edge capture,
// per-bit interrupt mask and a level IRQ driven by edges or by the synced data.
module nios_system_pio_in_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] HOLDOFF_INIT = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [31:0]      r_readdata;
  logic [2:0]       r_holdoff;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_det;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [31:0]      w_rd_mux;
  logic             w_unused;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_wr     = chipselect & ~write_n;
  assign w_unused = &{1'b0, writedata};

  // Synchronizer chain and previous-sample register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync;
    end
  end

  // Start-up hold-off: blocks captures until the chain holds real input data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_holdoff <= HOLDOFF_INIT;
    end else if (r_holdoff != 3'd0) begin
      r_holdoff <= r_holdoff - 3'd1;
    end else begin
      r_holdoff <= r_holdoff;
    end
  end

  // Edge detection selected by EDGE_TYPE, suppressed during hold-off
  always_comb begin
    w_rise = w_sync & ~r_prev;
    w_fall = ~w_sync & r_prev;
    if (r_holdoff != 3'd0) begin
      w_det = '0;
    end else if (EDGE_TYPE == 0) begin
      w_det = w_rise;
    end else if (EDGE_TYPE == 1) begin
      w_det = w_fall;
    end else begin
      w_det = w_rise | w_fall;
    end
  end

  // Write-1-to-clear strobe for the edgecapture register
  always_comb begin
    if (w_wr && (address == 2'd3)) begin
      w_clr = writedata[WIDTH-1:0];
    end else begin
      w_clr = '0;
    end
  end

  // Interrupt mask and sticky edgecapture; a new edge beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
      r_edge <= '0;
    end else begin
      if (w_wr && (address == 2'd2)) begin
        r_mask <= writedata[WIDTH-1:0];
      end else begin
        r_mask <= r_mask;
      end
      r_edge <= (r_edge & ~w_clr) | w_det;
    end
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    w_rd_mux = 32'd0;
    case (address)
      2'd0:    w_rd_mux[WIDTH-1:0] = w_sync;
      2'd1:    w_rd_mux = 32'd0;
      2'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
      2'd3:    w_rd_mux[WIDTH-1:0] = r_edge;
      default: w_rd_mux = 32'd0;
    endcase
  end

  // Registered read data, updated every cycle regardless of chipselect
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= 32'd0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign irq = (IRQ_MODE == 1) ? |(r_edge & r_mask) : |(w_sync & r_mask);

endmodule

// File: tb/tb_nios_system_pio_in_edge.sv
// Directed bench: a vector table for the default configuration plus hand-written
// sequences for any-edge capture, level IRQ mode and mid-operation reset.
module tb_nios_system_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        cs;
  logic        wn;
  logic [31:0] wd;
  logic [7:0]  inp;
  logic [31:0] rd;
  logic        irq;

  logic [1:0]  a_addr;
  logic        a_cs;
  logic        a_wn;
  logic [31:0] a_wd;
  logic [7:0]  a_in;
  logic [31:0] a_rd;
  logic        a_irq;

  logic [1:0]  l_addr;
  logic        l_cs;
  logic        l_wn;
  logic [31:0] l_wd;
  logic [7:0]  l_in;
  logic [31:0] l_rd;
  logic        l_irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nios_system_pio_in_edge dut (
    .clk(clk), .reset(reset), .address(addr), .chipselect(cs), .write_n(wn),
    .writedata(wd), .in_port(inp), .readdata(rd), .irq(irq)
  );

  nios_system_pio_in_edge #(.EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset(reset), .address(a_addr), .chipselect(a_cs), .write_n(a_wn),
    .writedata(a_wd), .in_port(a_in), .readdata(a_rd), .irq(a_irq)
  );

  nios_system_pio_in_edge #(.IRQ_MODE(0)) dut_lvl (
    .clk(clk), .reset(reset), .address(l_addr), .chipselect(l_cs), .write_n(l_wn),
    .writedata(l_wd), .in_port(l_in), .readdata(l_rd), .irq(l_irq)
  );

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [7:0]  inp;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] a, input logic c, input logic w, input logic [31:0] d,
                     input logic [7:0] i, input logic [31:0] er, input logic ei);
    vecs.push_back('{addr: a, cs: c, wn: w, wd: d, inp: i, exp_rd: er, exp_irq: ei});
  endtask

  initial begin
    reset = 1'b1;
    addr = 2'd0; cs = 1'b0; wn = 1'b1; wd = 32'd0; inp = 8'hFF;
    a_addr = 2'd0; a_cs = 1'b0; a_wn = 1'b1; a_wd = 32'd0; a_in = 8'h00;
    l_addr = 2'd0; l_cs = 1'b0; l_wn = 1'b1; l_wd = 32'd0; l_in = 8'h00;

    // hold-off with input high through reset release, then first rising edge
    add(2'd0, 1'b0, 1'b1, 32'd0, 8'hFF, 32'h00, 1'b0);
    add(2'd0, 1'b0, 1'b1, 32'd0, 8'hFF, 32'h00, 1'b0);
    add(2'd0, 1'b0, 1'b1, 32'd0, 8'hFF, 32'hFF, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'hFF, 32'h00, 1'b0);
    add(2'd2, 1'b1, 1'b0, 32'd1, 8'h00, 32'h00, 1'b0);
    add(2'd2, 1'b0, 1'b1, 32'd0, 8'h00, 32'h01, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'h00, 32'h00, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'h01, 32'h00, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'h01, 32'h00, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'h01, 32'h00, 1'b1);
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'h00, 32'h01, 1'b1);
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'h00, 32'h01, 1'b1);
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'h00, 32'h01, 1'b1);
    // second edge coinciding with a clear, then a clear with no edge
    add(2'd0, 1'b0, 1'b1, 32'd0, 8'h01, 32'h00, 1'b1);
    add(2'd0, 1'b0, 1'b1, 32'd0, 8'h01, 32'h00, 1'b1);
    add(2'd3, 1'b1, 1'b0, 32'd1, 8'h01, 32'h01, 1'b1);
    add(2'd3, 1'b1, 1'b0, 32'd1, 8'h01, 32'h01, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'h01, 32'h00, 1'b0);
    // recapture, then mask off keeps edgecapture; writes to addr 0/1 ignored
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'h00, 32'h00, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'h00, 32'h00, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'h01, 32'h00, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'h01, 32'h00, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'h01, 32'h00, 1'b1);
    add(2'd2, 1'b1, 1'b0, 32'd0, 8'h01, 32'h01, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'h01, 32'h01, 1'b0);
    add(2'd2, 1'b0, 1'b1, 32'd0, 8'h01, 32'h00, 1'b0);
    add(2'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 8'h01, 32'h01, 1'b0);
    add(2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 8'h01, 32'h00, 1'b0);
    add(2'd2, 1'b0, 1'b1, 32'd0, 8'h01, 32'h00, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'd0, 8'h01, 32'h01, 1'b0);

    step();
    chk("reset_rd", rd, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_irq_any", {31'd0, a_irq}, 32'd0);
    chk("reset_irq_lvl", {31'd0, l_irq}, 32'd0);
    reset = 1'b0;

    for (int n = 0; n < vecs.size(); n++) begin
      addr = vecs[n].addr; cs = vecs[n].cs; wn = vecs[n].wn;
      wd = vecs[n].wd; inp = vecs[n].inp;
      step();
      chk($sformatf("vec%0d_rd", n), rd, vecs[n].exp_rd);
      chk($sformatf("vec%0d_irq", n), {31'd0, irq}, {31'd0, vecs[n].exp_irq});
    end
    cs = 1'b0; wn = 1'b1;

    // any-edge capture on bit3: rise, clear, fall
    a_addr = 2'd2; a_cs = 1'b1; a_wn = 1'b0; a_wd = 32'h08;
    step();
    a_cs = 1'b0; a_wn = 1'b1; a_addr = 2'd3; a_in = 8'h08;
    step(); step(); step();
    chk("any_rise_irq", {31'd0, a_irq}, 32'd1);
    step();
    chk("any_rise_rd", a_rd, 32'h08);
    a_cs = 1'b1; a_wn = 1'b0; a_wd = 32'h08;
    step();
    a_cs = 1'b0; a_wn = 1'b1;
    chk("any_clr_irq", {31'd0, a_irq}, 32'd0);
    step();
    chk("any_clr_rd", a_rd, 32'h00);
    a_in = 8'h00;
    step(); step(); step();
    chk("any_fall_irq", {31'd0, a_irq}, 32'd1);
    step();
    chk("any_fall_rd", a_rd, 32'h08);

    // level interrupt mode on bit7
    l_addr = 2'd2; l_cs = 1'b1; l_wn = 1'b0; l_wd = 32'h80;
    step();
    l_cs = 1'b0; l_wn = 1'b1; l_in = 8'h80;
    step();
    chk("lvl_irq_s0", {31'd0, l_irq}, 32'd0);
    step();
    chk("lvl_irq_high", {31'd0, l_irq}, 32'd1);
    l_addr = 2'd3; l_cs = 1'b1; l_wn = 1'b0; l_wd = 32'hFF;
    step();
    l_cs = 1'b0; l_wn = 1'b1;
    chk("lvl_irq_after_clr", {31'd0, l_irq}, 32'd1);
    l_in = 8'h00;
    step();
    chk("lvl_irq_hold", {31'd0, l_irq}, 32'd1);
    step();
    chk("lvl_irq_low", {31'd0, l_irq}, 32'd0);

    // reset mid-operation with edgecapture=A5, mask=FF
    addr = 2'd2; cs = 1'b1; wn = 1'b0; wd = 32'hFF; inp = 8'h01;
    step();
    cs = 1'b0; wn = 1'b1; addr = 2'd3; inp = 8'hA5;
    step(); step(); step();
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    step();
    chk("pre_rst_rd", rd, 32'hA5);
    reset = 1'b1; cs = 1'b1; wn = 1'b0; wd = 32'hFF;
    step();
    chk("mid_rst_rd", rd, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0; cs = 1'b0; wn = 1'b1; addr = 2'd2;
    step();
    addr = 2'd3;
    step();
    chk("post_rst_mask", rd, 32'd0);
    step(); step(); step();
    chk("post_rst_edge", rd, 32'd0);
    chk("post_rst_irq", {31'd0, irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
